play_bus0: RTL and testbench

- Teaching-lab "play bus": a shared 4-bit data bus with three possible sources, each with its own output-enable: a fixed EPROM, a small RAM, and four switches.
- There are two sinks: the RAM (write) and an LED latch.
- Two 7-segment outputs show the live bus value and the latched LED value.
- Memory accesses use one fixed address; the block sits at the top of the bus lab and is driven directly by control switches and a manual clock.

---
 rtl/play_bus0_if.sv | 22 ++
 rtl/play_bus0.sv | 67 ++++++
 tb/tb_play_bus0.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/play_bus0_if.sv
// Control and display signals of the play bus lab block.
// The bench drives the master side; the play bus itself is the slave.
interface play_bus0_if;
    logic [3:0] sw0;
    logic       ROMO;
    logic       RAMO;
    logic       SWBEN;
    logic       RAMW;
    logic       LEDLTCH;
    logic [6:0] disp0;
    logic [6:0] disp1;

    modport master (
        output sw0, ROMO, RAMO, SWBEN, RAMW, LEDLTCH,
        input  disp0, disp1
    );

    modport slave (
        input  sw0, ROMO, RAMO, SWBEN, RAMW, LEDLTCH,
        output disp0, disp1
    );
endinterface

// File: rtl/play_bus0.sv
// Teaching-lab play bus: switches, EPROM and RAM share a 4-bit bus.
// The RAM and an LED latch capture the bus on the falling edge of n_clk.
module play_bus0 #(
    parameter logic [3:0] ADDR = 4'd5
) (
    input  logic        n_clk,
    input  logic        n_reset,
    play_bus0_if.slave  pb
);

    logic [3:0] ram [16];
    logic [3:0] led;
    logic [3:0] bus_val;
    logic       driven;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // EPROM contents are the complement of the address, so no table is stored.
    always_comb begin
        driven  = pb.SWBEN | pb.ROMO | pb.RAMO;
        bus_val = 4'h0;
        if (pb.SWBEN)
            bus_val = pb.sw0;
        else if (pb.ROMO)
            bus_val = ~ADDR;
        else if (pb.RAMO)
            bus_val = ram[ADDR];
    end

    always_ff @(negedge n_clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < 16; i++)
                ram[i] <= 4'h0;
            led <= 4'h0;
        end else begin
            if (pb.RAMW)
                ram[ADDR] <= bus_val;
            if (pb.LEDLTCH)
                led <= bus_val;
        end
    end

    assign pb.disp0 = driven ? seg7(bus_val) : 7'h00;
    assign pb.disp1 = seg7(led);

endmodule

// File: tb/tb_play_bus0.sv
// Directed bench for the play bus: bus priority, RAM/LED capture and async reset.
module tb_play_bus0;
    logic n_clk;
    logic n_reset;
    int   checks;
    int   failures;

    play_bus0_if pb ();

    play_bus0 #(.ADDR(4'd5)) dut (
        .n_clk   (n_clk),
        .n_reset (n_reset),
        .pb      (pb.slave)
    );

    task automatic idle();
        pb.sw0 = 4'h0; pb.SWBEN = 0; pb.ROMO = 0; pb.RAMO = 0;
        pb.RAMW = 0; pb.LEDLTCH = 0;
        #5;
    endtask

    // One manual clock: falling edge captures, rising edge must not.
    task automatic tick();
        n_clk = 1'b0; #5;
        n_clk = 1'b1; #5;
    endtask

    task automatic test_reset();
        n_reset = 1'b0; n_clk = 1'b1;
        idle();
        checks++;
        if (pb.disp0 !== 7'h00) begin
            failures++; $display("FAIL reset_disp0 got=%h exp=%h", pb.disp0, 7'h00);
        end
        checks++;
        if (pb.disp1 !== 7'h3F) begin
            failures++; $display("FAIL reset_disp1 got=%h exp=%h", pb.disp1, 7'h3F);
        end
        n_reset = 1'b1; #5;
        pb.ROMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h77) begin
            failures++; $display("FAIL rom_read got=%h exp=%h", pb.disp0, 7'h77);
        end
        pb.ROMO = 0; pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h3F) begin
            failures++; $display("FAIL ram_read_init got=%h exp=%h", pb.disp0, 7'h3F);
        end
        idle();
    endtask

    task automatic test_priority();
        pb.sw0 = 4'h2; pb.SWBEN = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h5B) begin
            failures++; $display("FAIL sw_read got=%h exp=%h", pb.disp0, 7'h5B);
        end
        pb.ROMO = 1; pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h5B) begin
            failures++; $display("FAIL sw_priority got=%h exp=%h", pb.disp0, 7'h5B);
        end
        pb.SWBEN = 0; #1;
        checks++;
        if (pb.disp0 !== 7'h77) begin
            failures++; $display("FAIL rom_over_ram got=%h exp=%h", pb.disp0, 7'h77);
        end
        idle();
    endtask

    task automatic test_ram_write();
        n_clk = 1'b0; #5;
        pb.sw0 = 4'h1; pb.SWBEN = 1; pb.RAMW = 1; #5;
        n_clk = 1'b1; #5;
        pb.SWBEN = 0; pb.RAMW = 0; pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h3F) begin
            failures++; $display("FAIL ram_rise_nowrite got=%h exp=%h", pb.disp0, 7'h3F);
        end
        pb.RAMO = 0; pb.SWBEN = 1; pb.RAMW = 1; #5;
        tick();
        idle();
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h06) begin
            failures++; $display("FAIL ram_write_sw got=%h exp=%h", pb.disp0, 7'h06);
        end
        idle();
        pb.ROMO = 1; pb.RAMW = 1; #5;
        tick();
        idle();
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h77) begin
            failures++; $display("FAIL ram_write_rom got=%h exp=%h", pb.disp0, 7'h77);
        end
        pb.RAMW = 1; #5;
        tick();
        pb.RAMW = 0; #1;
        checks++;
        if (pb.disp0 !== 7'h77) begin
            failures++; $display("FAIL ram_self_write got=%h exp=%h", pb.disp0, 7'h77);
        end
        idle();
        pb.sw0 = 4'h4; pb.SWBEN = 1; #5;
        tick();
        idle();
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h77) begin
            failures++; $display("FAIL ram_no_we got=%h exp=%h", pb.disp0, 7'h77);
        end
        idle();
    endtask

    task automatic test_led();
        pb.sw0 = 4'h6; pb.SWBEN = 1; pb.LEDLTCH = 1; #5;
        tick();
        checks++;
        if (pb.disp1 !== 7'h7D) begin
            failures++; $display("FAIL led_sw got=%h exp=%h", pb.disp1, 7'h7D);
        end
        pb.LEDLTCH = 0; pb.sw0 = 4'hC; #5;
        tick();
        checks++;
        if (pb.disp1 !== 7'h7D) begin
            failures++; $display("FAIL led_hold got=%h exp=%h", pb.disp1, 7'h7D);
        end
        idle();
        pb.ROMO = 1; pb.LEDLTCH = 1; #5;
        tick();
        checks++;
        if (pb.disp1 !== 7'h77) begin
            failures++; $display("FAIL led_rom got=%h exp=%h", pb.disp1, 7'h77);
        end
        idle();
        pb.sw0 = 4'h3; pb.SWBEN = 1; pb.LEDLTCH = 1; #5;
        tick();
        checks++;
        if (pb.disp1 !== 7'h4F) begin
            failures++; $display("FAIL led_sw3 got=%h exp=%h", pb.disp1, 7'h4F);
        end
        idle();
        pb.RAMO = 1; pb.LEDLTCH = 1; #5;
        tick();
        checks++;
        if (pb.disp1 !== 7'h77) begin
            failures++; $display("FAIL led_ram got=%h exp=%h", pb.disp1, 7'h77);
        end
        idle();
        pb.LEDLTCH = 1; #5;
        tick();
        checks++;
        if (pb.disp1 !== 7'h3F) begin
            failures++; $display("FAIL led_undriven got=%h exp=%h", pb.disp1, 7'h3F);
        end
        checks++;
        if (pb.disp0 !== 7'h00) begin
            failures++; $display("FAIL bus_blank got=%h exp=%h", pb.disp0, 7'h00);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        pb.sw0 = 4'h9; pb.SWBEN = 1; pb.RAMW = 1; pb.LEDLTCH = 1; #5;
        tick();
        idle();
        checks++;
        if (pb.disp1 !== 7'h6F) begin
            failures++; $display("FAIL both_led got=%h exp=%h", pb.disp1, 7'h6F);
        end
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h6F) begin
            failures++; $display("FAIL both_ram got=%h exp=%h", pb.disp0, 7'h6F);
        end
        idle();
    endtask

    task automatic test_async_reset();
        pb.ROMO = 1; pb.RAMW = 1; #5;
        tick();
        idle();
        pb.sw0 = 4'h6; pb.SWBEN = 1; pb.LEDLTCH = 1; #5;
        tick();
        idle();
        checks++;
        if (pb.disp1 !== 7'h7D) begin
            failures++; $display("FAIL pre_reset_led got=%h exp=%h", pb.disp1, 7'h7D);
        end
        #2 n_reset = 1'b0; #1;
        checks++;
        if (pb.disp1 !== 7'h3F) begin
            failures++; $display("FAIL async_led got=%h exp=%h", pb.disp1, 7'h3F);
        end
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h3F) begin
            failures++; $display("FAIL async_ram got=%h exp=%h", pb.disp0, 7'h3F);
        end
        idle();
        pb.sw0 = 4'h7; pb.SWBEN = 1; pb.RAMW = 1; pb.LEDLTCH = 1; #5;
        tick();
        idle();
        checks++;
        if (pb.disp1 !== 7'h3F) begin
            failures++; $display("FAIL held_led got=%h exp=%h", pb.disp1, 7'h3F);
        end
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h3F) begin
            failures++; $display("FAIL held_ram got=%h exp=%h", pb.disp0, 7'h3F);
        end
        idle();
        n_reset = 1'b1; #5;
        pb.sw0 = 4'h7; pb.SWBEN = 1; pb.RAMW = 1; #5;
        tick();
        idle();
        pb.RAMO = 1; #1;
        checks++;
        if (pb.disp0 !== 7'h07) begin
            failures++; $display("FAIL post_reset_write got=%h exp=%h", pb.disp0, 7'h07);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        n_clk = 1'b1;
        n_reset = 1'b0;
        test_reset();
        test_priority();
        test_ram_write();
        test_led();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
